// File: rtl/image_writer.sv
// -----------------------------------------------------------------------------
// image_writer
// Streams an 8-bit pixel frame into memory through an AXI4 write master.
// Pixels are packed four-to-a-word (first pixel in the low byte), buffered in a
// word FIFO of 2*BURST_SIZE entries, and written as INCR bursts of up to
// BURST_SIZE beats starting at the address sampled when the frame is started.
//
// Ports
//   i_clk, i_reset            clock, asynchronous active-high reset
//   i_ddrStartAddr            frame base byte address (sampled on start)
//   i_start                   rising edge requests a frame (honoured in IDLE)
//   i_img_data/_valid         pixel stream in; o_img_data_ready accepts
//   o_done                    one-cycle pulse after the frame's last B response
//   o_error                   sticky: some B response was not OKAY
//   m00_axi_aw*/w*/b*         AXI4 write address/data/response channels
// -----------------------------------------------------------------------------
module image_writer #(
   parameter int IMAGE_SIZE = 640*480,
   parameter int BURST_SIZE = 256
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [31:0] i_ddrStartAddr,
   input  logic        i_start,
   input  logic [7:0]  i_img_data,
   input  logic        i_img_data_valid,
   output logic        o_img_data_ready,
   output logic        o_done,
   output logic        o_error,
   output logic        m00_axi_awid,
   output logic [31:0] m00_axi_awaddr,
   output logic [7:0]  m00_axi_awlen,
   output logic [2:0]  m00_axi_awsize,
   output logic [1:0]  m00_axi_awburst,
   output logic        m00_axi_awlock,
   output logic [3:0]  m00_axi_awcache,
   output logic [2:0]  m00_axi_awprot,
   output logic [3:0]  m00_axi_awqos,
   output logic        m00_axi_awuser,
   output logic        m00_axi_awvalid,
   input  logic        m00_axi_awready,
   output logic [31:0] m00_axi_wdata,
   output logic [3:0]  m00_axi_wstrb,
   output logic        m00_axi_wlast,
   output logic        m00_axi_wuser,
   output logic        m00_axi_wvalid,
   input  logic        m00_axi_wready,
   input  logic        m00_axi_bid,
   input  logic [1:0]  m00_axi_bresp,
   input  logic        m00_axi_buser,
   input  logic        m00_axi_bvalid,
   output logic        m00_axi_bready
);

   localparam int FIFO_DEPTH = 2 * BURST_SIZE;
   localparam int PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

   localparam logic [31:0]      IMAGE_BYTES   = 32'(IMAGE_SIZE);
   localparam logic [31:0]      BURST_WORDS   = 32'(BURST_SIZE);
   localparam logic [CNT_W-1:0] FIFO_FULL_CNT = CNT_W'(FIFO_DEPTH);
   localparam logic [PTR_W-1:0] PTR_LAST      = PTR_W'(FIFO_DEPTH - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAITDATA,
      S_ADDR,
      S_DATA,
      S_RESP
   } state_t;

   state_t state;

   // start edge detector
   logic start_q;
   logic start_edge;
   logic start_accept;

   // frame bookkeeping
   logic [31:0] addr;
   logic [31:0] bytes_remaining;
   logic [31:0] words_remaining;
   logic [31:0] burst_len;
   logic [31:0] len_bytes;
   logic [8:0]  len_q;
   logic [8:0]  beat_cnt;
   logic [7:0]  awlen_q;
   logic        awvalid_q;
   logic        bready_q;
   logic        done_q;
   logic        error_q;

   // pixel packer
   logic [31:0] pix_count;
   logic [1:0]  byte_idx;
   logic [23:0] pack;
   logic        accept;

   // word FIFO
   logic [31:0]      mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] fifo_count;
   logic             fifo_full;
   logic             fifo_empty;
   logic             push;
   logic             pop;

   // ---------------------------------------------------------------------------
   // Constant AXI attributes: single-ID, 4-byte INCR bursts, all lanes valid.
   // ---------------------------------------------------------------------------
   assign m00_axi_awid    = 1'b0;
   assign m00_axi_awsize  = 3'b010;
   assign m00_axi_awburst = 2'b01;
   assign m00_axi_awlock  = 1'b0;
   assign m00_axi_awcache = 4'd0;
   assign m00_axi_awprot  = 3'd0;
   assign m00_axi_awqos   = 4'd0;
   assign m00_axi_awuser  = 1'b0;
   assign m00_axi_wstrb   = 4'hF;
   assign m00_axi_wuser   = 1'b0;

   assign m00_axi_awaddr  = addr;
   assign m00_axi_awlen   = awlen_q;
   assign m00_axi_awvalid = awvalid_q;
   assign m00_axi_bready  = bready_q;
   assign o_done          = done_q;
   assign o_error         = error_q;

   // ---------------------------------------------------------------------------
   // Datapath decode
   // ---------------------------------------------------------------------------
   assign fifo_full        = (fifo_count == FIFO_FULL_CNT);
   assign fifo_empty       = (fifo_count == '0);
   assign o_img_data_ready = (state != S_IDLE) && (pix_count < IMAGE_BYTES) && !fifo_full;
   assign accept           = i_img_data_valid && o_img_data_ready;
   assign push             = accept && (byte_idx == 2'd3);

   // Data is only offered after the address handshake, so AW and W never overlap.
   assign m00_axi_wvalid = (state == S_DATA) && !fifo_empty;
   assign m00_axi_wdata  = mem[rd_ptr];
   assign m00_axi_wlast  = m00_axi_wvalid && ((beat_cnt + 9'd1) == len_q);
   assign pop            = m00_axi_wvalid && m00_axi_wready;

   assign start_accept    = (state == S_IDLE) && start_edge;
   assign words_remaining = {2'b00, bytes_remaining[31:2]};
   assign len_bytes       = {21'd0, len_q, 2'b00};

   // NOTE: default assignment first so every path drives burst_len -- no latch.
   always_comb begin
      burst_len = words_remaining;
      if (words_remaining > BURST_WORDS) burst_len = BURST_WORDS;
   end

   // ---------------------------------------------------------------------------
   // Start edge detector: a one-cycle registered pulse, only consumed in IDLE.
   // ---------------------------------------------------------------------------
   // NOTE: state is updated with <= so every register samples pre-edge values.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         start_q    <= 1'b0;
         start_edge <= 1'b0;
      end else begin
         start_q    <= i_start;
         start_edge <= i_start & ~start_q;
      end
   end

   // ---------------------------------------------------------------------------
   // Pixel packer and FIFO pointers
   // ---------------------------------------------------------------------------
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         pix_count  <= '0;
         byte_idx   <= '0;
         pack       <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (start_accept) begin
            pix_count <= '0;
            byte_idx  <= '0;
         end else if (accept) begin
            pix_count <= pix_count + 32'd1;
            byte_idx  <= byte_idx + 2'd1;
            case (byte_idx)
               2'd0:    pack[7:0]   <= i_img_data;
               2'd1:    pack[15:8]  <= i_img_data;
               2'd2:    pack[23:16] <= i_img_data;
               default: ;   // fourth byte goes straight into the FIFO
            endcase
         end

         if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);

         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CNT_W'(1);
            2'b01:   fifo_count <= fifo_count - CNT_W'(1);
            default: ;   // idle, or push and pop cancel out
         endcase
      end
   end

   // NOTE: FIFO storage is not reset; the reset pointers and count make it empty.
   always_ff @(posedge i_clk) begin
      if (push) mem[wr_ptr] <= {i_img_data, pack};
   end

   // ---------------------------------------------------------------------------
   // Burst control FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state           <= S_IDLE;
         addr            <= '0;
         bytes_remaining <= '0;
         len_q           <= '0;
         beat_cnt        <= '0;
         awlen_q         <= '0;
         awvalid_q       <= 1'b0;
         bready_q        <= 1'b0;
         done_q          <= 1'b0;
         error_q         <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start_edge) begin
                  addr            <= i_ddrStartAddr;
                  bytes_remaining <= IMAGE_BYTES;
                  error_q         <= 1'b0;
                  state           <= S_WAITDATA;
               end
            end

            // Wait until a whole burst is buffered so W never stalls on data.
            S_WAITDATA: begin
               if (32'(fifo_count) >= burst_len) begin
                  len_q     <= burst_len[8:0];
                  awlen_q   <= 8'(burst_len - 32'd1);
                  awvalid_q <= 1'b1;
                  state     <= S_ADDR;
               end
            end

            S_ADDR: begin
               if (m00_axi_awready) begin
                  awvalid_q <= 1'b0;
                  beat_cnt  <= '0;
                  state     <= S_DATA;
               end
            end

            S_DATA: begin
               if (pop) begin
                  beat_cnt <= beat_cnt + 9'd1;
                  if (m00_axi_wlast) begin
                     bready_q <= 1'b1;
                     state    <= S_RESP;
                  end
               end
            end

            S_RESP: begin
               if (m00_axi_bvalid) begin
                  bready_q        <= 1'b0;
                  error_q         <= error_q | (m00_axi_bresp != 2'b00);
                  addr            <= addr + len_bytes;
                  bytes_remaining <= bytes_remaining - len_bytes;
                  if (bytes_remaining == len_bytes) begin
                     done_q <= 1'b1;
                     state  <= S_IDLE;
                  end else begin
                     state  <= S_WAITDATA;
                  end
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

   // B-channel ID/user carry nothing for a single-ID master; the low address
   // bits of the byte count are always zero for a word-multiple frame.
   logic unused_ok;
   assign unused_ok = ^{m00_axi_bid, m00_axi_buser, bytes_remaining[1:0]};

endmodule

// File: tb/tb_image_writer.sv
// -----------------------------------------------------------------------------
// tb_image_writer
// Self-checking bench for image_writer (IMAGE_SIZE=24, BURST_SIZE=4).
// A responsive AXI slave with configurable AW stall, W ready pattern and B
// response captures every burst; a frame-level reference model derives the
// expected AW/W sequence from the pixel bytes and the base address.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_image_writer;

   localparam int IMG   = 24;
   localparam int BURST = 4;
   localparam int WORDS = IMG / 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] start_addr = '0;
   logic        start = 1'b0;
   logic [7:0]  img_data = '0;
   logic        img_valid = 1'b0;
   logic        img_ready, done, error;
   logic        awid, awlock, awuser, awvalid;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic [2:0]  awsize, awprot;
   logic [1:0]  awburst;
   logic [3:0]  awcache, awqos;
   logic        awready = 1'b0;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast, wuser, wvalid;
   logic        wready = 1'b0;
   logic        bid = 1'b0, buser = 1'b0;
   logic [1:0]  bresp = 2'b00;
   logic        bvalid = 1'b0;
   logic        bready;

   always #5 clk = ~clk;

   image_writer #(.IMAGE_SIZE(IMG), .BURST_SIZE(BURST)) dut (
      .i_clk(clk), .i_reset(rst), .i_ddrStartAddr(start_addr), .i_start(start),
      .i_img_data(img_data), .i_img_data_valid(img_valid), .o_img_data_ready(img_ready),
      .o_done(done), .o_error(error),
      .m00_axi_awid(awid), .m00_axi_awaddr(awaddr), .m00_axi_awlen(awlen),
      .m00_axi_awsize(awsize), .m00_axi_awburst(awburst), .m00_axi_awlock(awlock),
      .m00_axi_awcache(awcache), .m00_axi_awprot(awprot), .m00_axi_awqos(awqos),
      .m00_axi_awuser(awuser), .m00_axi_awvalid(awvalid), .m00_axi_awready(awready),
      .m00_axi_wdata(wdata), .m00_axi_wstrb(wstrb), .m00_axi_wlast(wlast),
      .m00_axi_wuser(wuser), .m00_axi_wvalid(wvalid), .m00_axi_wready(wready),
      .m00_axi_bid(bid), .m00_axi_bresp(bresp), .m00_axi_buser(buser),
      .m00_axi_bvalid(bvalid), .m00_axi_bready(bready)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Slave / monitor state
   // ---------------------------------------------------------------------------
   logic [39:0] aw_q[$];          // {awlen, awaddr}
   logic [32:0] w_q[$];           // {wlast, wdata}
   int          done_cnt = 0;
   int          wlast_cnt = 0;
   int          pend_b = 0;
   int          b_idx = 0;
   int          aw_stall = 0;
   int          aw_delay = 0;
   int          wmode = 0;        // 0: always ready, 1: toggle, 2: random
   logic [1:0]  resp_first = 2'b00;
   logic        err_at_done = 1'b0;
   logic        aw_hold = 1'b0;
   logic [31:0] hold_addr = '0;
   logic [7:0]  hold_len = '0;

   logic [7:0]  pix [IMG];
   bit          abort_px = 1'b0;
   int          px_sent = 0;

   initial begin
      logic aw_hs, w_hs, b_hs;
      forever begin
         @(negedge clk);
         aw_hs = awvalid & awready;
         w_hs  = wvalid & wready;
         b_hs  = bvalid & bready;

         check("aw_w_exclusive", awvalid & wvalid, 1'b0);
         if (wvalid && !rst) check("w_after_aw", aw_q.size() > wlast_cnt, 1'b1);
         if (aw_hold && !rst)
            check("aw_stable", {awvalid, awaddr, awlen}, {1'b1, hold_addr, hold_len});
         aw_hold   = awvalid && !awready && !rst;
         hold_addr = awaddr;
         hold_len  = awlen;

         if (aw_hs) aw_q.push_back({awlen, awaddr});
         if (w_hs) begin
            w_q.push_back({wlast, wdata});
            if (wlast) begin
               wlast_cnt++;
               pend_b++;
            end
         end
         if (b_hs) begin
            pend_b--;
            b_idx++;
         end
         if (done) begin
            done_cnt++;
            err_at_done = error;
         end
         if (aw_hs) aw_stall = 0;
         else if (awvalid && !awready) aw_stall++;

         @(posedge clk); #1;
         if (rst) begin
            bvalid = 1'b0; pend_b = 0; aw_stall = 0;
         end else begin
            if (b_hs) bvalid = 1'b0;
            if (!bvalid && pend_b > 0 && $urandom_range(1) == 1) begin
               bvalid = 1'b1;
               bresp  = (b_idx == 0) ? resp_first : 2'b00;
            end
            awready = (aw_stall >= aw_delay);
            case (wmode)
               0:       wready = 1'b1;
               1:       wready = ~wready;
               default: wready = ($urandom_range(3) != 0);
            endcase
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus helpers
   // ---------------------------------------------------------------------------
   task automatic send_pixels(input int gap);
      int guard = 0;
      px_sent = 0;
      while (px_sent < IMG && !abort_px && guard < 4000) begin
         @(posedge clk); #1;
         img_valid = ($urandom_range(99) >= gap);
         img_data  = pix[px_sent];
         @(negedge clk);
         if (img_valid && img_ready && !rst) px_sent++;
         guard++;
      end
      @(posedge clk); #1;
      img_valid = 1'b0;
      @(negedge clk);
      if (px_sent == IMG && !abort_px) check("ready_after_frame", img_ready, 1'b0);
   endtask

   task automatic pulse_start();
      @(posedge clk); #1; start = 1'b1;
      repeat (2) @(posedge clk);
      #1; start = 1'b0;
   endtask

   task automatic run_frame(input string name, input logic [31:0] base, input bit seq,
                            input int awd, input int wm, input int gap,
                            input logic [1:0] r1, input bit late_start);
      logic [31:0] words [WORDS];
      logic [39:0] exp_aw[$];
      logic [32:0] exp_w[$];
      logic [31:0] a;
      int rem, n, idx, budget;

      for (int i = 0; i < IMG; i++) pix[i] = seq ? 8'(i) : 8'($urandom);
      // Reference: little-endian word packing, bursts of min(BURST, words left).
      for (int k = 0; k < WORDS; k++)
         words[k] = {pix[4*k+3], pix[4*k+2], pix[4*k+1], pix[4*k]};
      a = base; rem = WORDS; idx = 0;
      while (rem > 0) begin
         n = (rem < BURST) ? rem : BURST;
         exp_aw.push_back({8'(n - 1), a});
         for (int j = 0; j < n; j++) begin
            exp_w.push_back({(j == n - 1), words[idx]});
            idx++;
         end
         a   = a + 32'(n * 4);
         rem = rem - n;
      end

      aw_q.delete(); w_q.delete();
      done_cnt = 0; wlast_cnt = 0; b_idx = 0;
      aw_delay = awd; wmode = wm; resp_first = r1; abort_px = 1'b0;
      start_addr = base;
      pulse_start();
      @(negedge clk);
      check({name, ":err_clear"}, error, 1'b0);

      fork
         send_pixels(gap);
         if (late_start) begin
            for (int k = 0; k < 2000 && w_q.size() == 0; k++) @(negedge clk);
            @(posedge clk); #1; start = 1'b1;
            repeat (2) @(posedge clk);
            #1; start = 1'b0;
         end
      join_none

      budget = 0;
      while (done_cnt == 0 && budget < 3000) begin
         @(negedge clk);
         budget++;
      end
      abort_px = 1'b1;
      wait fork;
      abort_px = 1'b0;
      repeat (20) @(negedge clk);

      check({name, ":done_cnt"}, done_cnt, 1);
      check({name, ":n_aw"}, aw_q.size(), exp_aw.size());
      check({name, ":n_w"}, w_q.size(), exp_w.size());
      foreach (exp_aw[k]) check({name, ":aw"}, (k < aw_q.size()) ? aw_q[k] : 'x, exp_aw[k]);
      foreach (exp_w[k])  check({name, ":w"},  (k < w_q.size())  ? w_q[k]  : 'x, exp_w[k]);
      check({name, ":err_at_done"}, err_at_done, r1 != 2'b00);
      check({name, ":err_sticky"}, error, r1 != 2'b00);
   endtask

   task automatic reset_mid_burst(input logic [31:0] base);
      for (int i = 0; i < IMG; i++) pix[i] = 8'($urandom);
      aw_q.delete(); w_q.delete();
      done_cnt = 0; wlast_cnt = 0; b_idx = 0;
      aw_delay = 0; wmode = 0; resp_first = 2'b00; abort_px = 1'b0;
      start_addr = base;
      pulse_start();
      fork
         send_pixels(0);
      join_none
      for (int k = 0; k < 2000 && w_q.size() == 0; k++) @(negedge clk);
      check("rst:reached_data", w_q.size() >= 1, 1'b1);
      // Beat 1 completes on the next edge; beat 2 is then on the bus.
      @(posedge clk); #2;
      check("rst:beat2_valid", wvalid, 1'b1);
      rst = 1'b1;
      #1;
      check("rst:outputs", {awvalid, wvalid, wlast, bready, img_ready, done, error},
            7'd0);
      check("rst:awaddr_awlen", {awaddr, awlen}, 40'd0);
      abort_px = 1'b1;
      wait fork;
      abort_px = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      repeat (10) @(negedge clk);
      check("rst:idle_no_start", {awvalid, img_ready, done}, 3'd0);
   endtask

   // ---------------------------------------------------------------------------
   // Test sequence
   // ---------------------------------------------------------------------------
   initial begin
      repeat (3) @(negedge clk);
      check("reset:outputs", {awvalid, wvalid, wlast, bready, img_ready, done, error}, 7'd0);
      check("reset:awaddr_awlen", {awaddr, awlen}, 40'd0);
      check("const:aw", {awid, awsize, awburst, awlock, awcache, awprot, awqos, awuser},
            {1'b0, 3'b010, 2'b01, 1'b0, 4'd0, 3'd0, 4'd0, 1'b0});
      check("const:w", {wstrb, wuser}, {4'hF, 1'b0});
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check("idle:ready_low", img_ready, 1'b0);

      // Sequential pixels from 0x1000 at full speed; spot-check the literal values.
      run_frame("basic", 32'h0000_1000, 1'b1, 0, 0, 0, 2'b00, 1'b0);
      check("basic:w0", (w_q.size() > 0) ? w_q[0] : 'x, {1'b0, 32'h0302_0100});
      check("basic:w3", (w_q.size() > 3) ? w_q[3] : 'x, {1'b1, 32'h0F0E_0D0C});
      check("basic:aw1", (aw_q.size() > 1) ? aw_q[1] : 'x, {8'd1, 32'h0000_1010});

      run_frame("aw_stall", 32'h0000_2000, 1'b0, 10, 0, 0, 2'b00, 1'b0);
      run_frame("w_toggle", 32'h0000_3000, 1'b0, 0, 1, 70, 2'b00, 1'b0);
      run_frame("bresp_err", 32'h0000_4000, 1'b0, 0, 0, 10, 2'b10, 1'b0);
      run_frame("late_start", 32'h0000_5000, 1'b0, 0, 2, 20, 2'b00, 1'b1);

      reset_mid_burst(32'h0000_6000);
      run_frame("post_reset", 32'h7000_0040, 1'b0, 1, 2, 30, 2'b00, 1'b0);

      run_frame("addr_wrap", 32'hFFFF_FFF4, 1'b0, 0, 0, 0, 2'b00, 1'b0);

      for (int r = 0; r < 4; r++)
         run_frame("random", $urandom & 32'hFFFF_FFFC, 1'b0, $urandom_range(3), 2,
                   $urandom_range(50), 2'($urandom_range(3)), 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
